// File: rtl/fpu_int2flt_pkg.sv
// Shared FPU definitions: rounding-mode encoding (common with the float-to-int
// converter), single-precision bias, and the int-to-float FSM state type.
package fpu_int2flt_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLT_BIAS = 127;
    // Exponent of a value whose leading one sits at bit 31.
    localparam logic [7:0] EXP_INIT = 8'(FLT_BIAS + 31);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fpu_int2flt_if.sv
// Operand/result handshake bundle for the integer-to-float converter.
interface fpu_int2flt_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic        signed_input;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        inexact;

    modport master (
        output in_valid, in, signed_input, rm, out_ready,
        input  in_ready, out_valid, out, inexact
    );

    modport slave (
        input  in_valid, in, signed_input, rm, out_ready,
        output in_ready, out_valid, out, inexact
    );
endinterface

// File: rtl/fpu_int2flt_lzc.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module fpu_lzc (
    input  logic [31:0] a,
    output logic [5:0]  lz
);
    always_comb begin
        lz = 6'd32;
        // Scanning upward, the last hit is the most significant one.
        for (int i = 0; i < 32; i++) begin
            if (a[i]) lz = 6'(31 - i);
        end
    end
endmodule

// File: rtl/fpu_int2flt.sv
// Multi-cycle int32/uint32 -> IEEE-754 single converter (FCVT.S.W / FCVT.S.WU).
// Define INT2FLT_FAST_NORM_EN for single-cycle normalization via fpu_lzc.
module fpu_int2flt
    import fpu_int2flt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fpu_int2flt_if.slave  io
);

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] res_q, res_d;
    logic        nx_q, nx_d;
    logic        ovld_q, ovld_d;
    logic        irdy_q, irdy_d;

    logic        cap_sign;
    logic [31:0] cap_mag;
    logic        lsb, g, r, s, round_up;
    logic [30:0] rnd_sum;

    assign cap_sign = io.signed_input & io.in[31];
    assign cap_mag  = cap_sign ? -io.in : io.in;

    assign lsb = mag_q[8];
    assign g   = mag_q[7];
    assign r   = mag_q[6];
    assign s   = |mag_q[5:0];

    always_comb begin
        round_up = 1'b0;
        case (rm_q)
            RM_RNE:  round_up = g & (r | s | lsb);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = (g | r | s) & sign_q;
            RM_RUP:  round_up = (g | r | s) & ~sign_q;
            RM_RMM:  round_up = g;
            default: round_up = 1'b0;
        endcase
    end

    // Mantissa carry ripples straight into the exponent field.
    assign rnd_sum = {exp_q, mag_q[30:8]} + 31'(round_up);

`ifdef INT2FLT_FAST_NORM_EN
    logic [5:0] lz;
    fpu_lzc u_lzc (.a(mag_q), .lz(lz));
`endif

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        rm_d    = rm_q;
        res_d   = res_q;
        nx_d    = nx_q;
        ovld_d  = ovld_q;
        case (state_q)
            ST_IDLE: begin
                if (io.in_valid && irdy_q) begin
                    sign_d = cap_sign;
                    mag_d  = cap_mag;
                    rm_d   = io.rm;
                    exp_d  = EXP_INIT;
                    if (cap_mag == 32'd0) begin
                        res_d   = 32'd0;
                        nx_d    = 1'b0;
                        ovld_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
`ifdef INT2FLT_FAST_NORM_EN
                mag_d   = mag_q << lz;
                exp_d   = EXP_INIT - {2'b00, lz};
                state_d = ST_ROUND;
`else
                if (mag_q[31]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
`endif
            end
            ST_ROUND: begin
                res_d   = {sign_q, rnd_sum};
                nx_d    = g | r | s;
                ovld_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (io.out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            rm_q    <= '0;
            res_q   <= '0;
            nx_q    <= 1'b0;
            ovld_q  <= 1'b0;
            irdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            rm_q    <= rm_d;
            res_q   <= res_d;
            nx_q    <= nx_d;
            ovld_q  <= ovld_d;
            irdy_q  <= irdy_d;
        end
    end

    assign io.in_ready  = irdy_q;
    assign io.out_valid = ovld_q;
    assign io.out       = res_q;
    assign io.inexact   = nx_q;

endmodule

// File: tb/tb_fpu_int2flt.sv
// Randomized self-checking bench for fpu_int2flt against an arithmetic reference.
module tb_fpu_int2flt;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    fpu_int2flt_if bus();

    fpu_int2flt dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        sg;
        logic [2:0]  r;
        logic [31:0] o;
        logic        nx;
    } vec_t;

    // Reference: exact magnitude, truncate to 24 significant bits, round on the remainder.
    task automatic ref_conv(input logic [31:0] a, input logic sg, input logic [2:0] r,
                            output logic [31:0] res, output logic nx, output int lat);
        bit s;
        longint unsigned m, q, rem, half;
        int p, e, sh;
        bit up;
        s = sg & a[31];
        m = s ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
        if (m == 0) begin
            res = 32'd0;
            nx = 1'b0;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 127 + p;
        up = 1'b0;
        rem = 0;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh = p - 23;
            q = m >> sh;
            rem = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            case (r)
                3'd0: up = (rem > half) || (rem == half && q[0]);
                3'd2: up = (rem != 0) && s;
                3'd3: up = (rem != 0) && !s;
                3'd4: up = (rem >= half);
                default: up = 1'b0;
            endcase
        end
        q = q + {63'd0, up};
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        res = {s, 8'(e), q[22:0]};
        nx = (rem != 0);
`ifdef INT2FLT_FAST_NORM_EN
        lat = 3;
`else
        lat = 3 + (31 - p);
`endif
    endtask

    task automatic issue(input logic [31:0] a, input logic sg, input logic [2:0] r);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL issue_wait: in_ready=%0b required 1 within 200 cycles", bus.in_ready);
        end
        bus.in = a;
        bus.signed_input = sg;
        bus.rm = r;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat <= 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: out_valid=0 required 1 within 200 edges");
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in = 32'd0;
        bus.signed_input = 1'b0;
        bus.rm = 3'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out, bus.inexact} !== 35'd0) begin
            bad++;
            $display("FAIL reset_vals: rdy=%0b vld=%0b out=%h nx=%0b required all 0",
                     bus.in_ready, bus.out_valid, bus.out, bus.inexact);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_early: in_ready=%0b required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: in_ready=%0b required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t dv [12];
        int lat, elat;
        logic [31:0] eo;
        logic enx;
        dv = '{
            '{32'h00000001, 1'b1, 3'd0, 32'h3F800000, 1'b0},
            '{32'hFFFFFFFF, 1'b1, 3'd0, 32'hBF800000, 1'b0},
            '{32'h80000000, 1'b1, 3'd0, 32'hCF000000, 1'b0},
            '{32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 1'b1},
            '{32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1},
            '{32'h01000001, 1'b0, 3'd0, 32'h4B800000, 1'b1},
            '{32'h01000001, 1'b0, 3'd3, 32'h4B800001, 1'b1},
            '{32'h01000001, 1'b0, 3'd4, 32'h4B800001, 1'b1},
            '{32'hFFFFFFFF, 1'b1, 3'd2, 32'hBF800000, 1'b0},
            '{32'hFEFFFFFF, 1'b1, 3'd2, 32'hCB800001, 1'b1},
            '{32'hFEFFFFFF, 1'b1, 3'd3, 32'hCB800000, 1'b1},
            '{32'h00000000, 1'b1, 3'd2, 32'h00000000, 1'b0}
        };
        foreach (dv[i]) begin
            ref_conv(dv[i].a, dv[i].sg, dv[i].r, eo, enx, elat);
            issue(dv[i].a, dv[i].sg, dv[i].r);
            wait_valid(lat);
            total++;
            if (bus.out !== dv[i].o || bus.inexact !== dv[i].nx) begin
                bad++;
                $display("FAIL directed[%0d] in=%h: out=%h nx=%0b required out=%h nx=%0b",
                         i, dv[i].a, bus.out, bus.inexact, dv[i].o, dv[i].nx);
            end
            total++;
            if (lat !== elat) begin
                bad++;
                $display("FAIL directed_lat[%0d] in=%h: latency=%0d required %0d", i, dv[i].a, lat, elat);
            end
            consume();
        end
    endtask

    task automatic test_random();
        int lat, elat;
        logic [31:0] a, eo;
        logic sg, enx;
        logic [2:0] r;
        for (int k = 0; k < 48; k++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            sg = 1'($urandom_range(0, 1));
            r = 3'($urandom_range(0, 7));
            ref_conv(a, sg, r, eo, enx, elat);
            issue(a, sg, r);
            wait_valid(lat);
            total++;
            if (bus.out !== eo || bus.inexact !== enx || lat !== elat) begin
                bad++;
                $display("FAIL random[%0d] in=%h sg=%0b rm=%0d: out=%h nx=%0b lat=%0d required out=%h nx=%0b lat=%0d",
                         k, a, sg, r, bus.out, bus.inexact, lat, eo, enx, elat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat, elat;
        logic [31:0] eo;
        logic enx;
        ref_conv(32'h12345678, 1'b0, 3'd0, eo, enx, elat);
        issue(32'h12345678, 1'b0, 3'd0);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out !== eo || bus.inexact !== enx || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure[%0d]: vld=%0b out=%h nx=%0b rdy=%0b required vld=1 out=%h nx=%0b rdy=0",
                         c, bus.out_valid, bus.out, bus.inexact, bus.in_ready, eo, enx);
            end
        end
        consume();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL handoff: vld=%0b rdy=%0b required vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_busy_ignored();
        int lat, elat;
        logic [31:0] eo;
        logic enx;
        ref_conv(32'h00F00001, 1'b0, 3'd3, eo, enx, elat);
        issue(32'h00F00001, 1'b0, 3'd3);
        bus.in = 32'hDEADBEEF;
        bus.signed_input = 1'b1;
        bus.rm = 3'd1;
        bus.in_valid = 1'b1;
        wait_valid(lat);
        bus.in_valid = 1'b0;
        total++;
        if (bus.out !== eo || bus.inexact !== enx || lat !== elat) begin
            bad++;
            $display("FAIL busy_ignored: out=%h nx=%0b lat=%0d required out=%h nx=%0b lat=%0d",
                     bus.out, bus.inexact, lat, eo, enx, elat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, elat;
        logic [31:0] eo;
        logic enx;
        for (int k = 0; k < 6; k++) begin
            ref_conv(32'(k * 1000003 + 7), 1'b1, 3'(k % 5), eo, enx, elat);
            issue(32'(k * 1000003 + 7), 1'b1, 3'(k % 5));
            wait_valid(lat);
            total++;
            if (bus.out !== eo || bus.inexact !== enx) begin
                bad++;
                $display("FAIL b2b[%0d]: out=%h nx=%0b required out=%h nx=%0b", k, bus.out, bus.inexact, eo, enx);
            end
            consume();
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: in_ready=%0b required 1", k, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(32'h00000003, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out, bus.inexact} !== 35'd0) begin
            bad++;
            $display("FAIL reset_mid: rdy=%0b vld=%0b out=%h nx=%0b required all 0",
                     bus.in_ready, bus.out_valid, bus.out, bus.inexact);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready: in_ready=%0b required 1", bus.in_ready);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_mid_noresult: out_valid cycles=%0d required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
